video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
//
// Purpose: free-running video timing generator with built-in test patterns.
// A three-state FSM (IDLE/RUN/DRAIN) gates a pixel/line counter pair; every
// output is a registered function of the counters, so syncs, data enable and
// pixel data leave the block with one cycle of latency and stay aligned.
// When enable drops, the frame in flight is finished (DRAIN) before the
// block returns to IDLE. As a result, every frame starts at pixel (0,0).
//
// Handshake: none. enable is a level "run request"; out_de qualifies
// out_data on every cycle (no back-pressure). frame_done is a single-cycle
// pulse that coincides with the final pixel's outputs.
//
// Ports:
//   opclk        in   pixel clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   run request
//   pattern_sel  in   0 h ramp, 1 v ramp, 2 colour bars, 3 frame count
//                     (sampled only at pixel (0,0))
//   out_vsync    out  vertical sync, active-high
//   out_hsync    out  horizontal sync, active-high
//   out_de       out  data enable
//   out_data     out  NUM_D components of DSIZE bits; component 0 is the MSB
//   frame_done   out  one-cycle pulse at the end of every frame
//   frame_cnt    out  completed-frame count, wraps 65535 -> 0
//   dbg_state_o  out  current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Build option: define VIDEO_GEN_FRAME_LIMIT_EN to stop generation once
// frame_cnt reaches FRAME_MAX; the block then ignores enable until reset.
// Without the macro generation is unlimited.
//
// Assumes H_TOTAL >= 8 so the horizontal counter can hold a bar index.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module video_pattern_gen #(
  parameter int DSIZE     = 8,
  parameter int NUM_D     = 3,
  parameter int H_ACTIVE  = 1920,
  parameter int H_FP      = 88,
  parameter int H_SYNC    = 44,
  parameter int H_BP      = 148,
  parameter int V_ACTIVE  = 1080,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 36,
  parameter int FRAME_MAX = 20
) (
  input  logic                   opclk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [1:0]             pattern_sel,
  output logic                   out_vsync,
  output logic                   out_hsync,
  output logic                   out_de,
  output logic [NUM_D*DSIZE-1:0] out_data,
  output logic                   frame_done,
  output logic [15:0]            frame_cnt,
  output logic [1:0]             dbg_state_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = NUM_D * DSIZE;
  // Bar width falls back to 1 for tiny active widths to avoid divide-by-0.
  localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_W_C    = HW'(BAR_W);
  localparam logic [HW-1:0] BAR_MAX    = HW'(7);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VIDEO_GEN_FRAME_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [1:0]      pat_q, pat_d;
  logic            limit_q, limit_d;
  logic            vs_q, vs_d;
  logic            hs_q, hs_d;
  logic            de_q, de_d;
  logic [DW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic [15:0]     fcnt_q, fcnt_d;

  logic            active;
  logic            h_last;
  logic            frame_end;
  logic            first_px;
  logic            limit_hit;
  logic [1:0]      pat_eff;
  logic [HW-1:0]   bar_raw;
  logic [2:0]      bar;
  logic [DSIZE-1:0] comp;

  assign active    = (state_q != IDLE);
  assign h_last    = (h_q == H_LAST);
  assign frame_end = active && h_last && (v_q == V_LAST);
  assign first_px  = active && (h_q == '0) && (v_q == '0);
  // The pattern for pixel (0,0) itself must already use the new selection.
  assign pat_eff   = first_px ? pattern_sel : pat_q;
  assign limit_hit = LIMIT_EN && frame_end && ((fcnt_q + 16'd1) == 16'(FRAME_MAX));

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    limit_d = limit_q | limit_hit;
    case (state_q)
      IDLE: begin
        if (enable && !limit_q) state_d = RUN;
      end
      RUN: begin
        if (limit_hit)                  state_d = IDLE;
        else if (!enable && frame_end)  state_d = IDLE;  // frame already complete
        else if (!enable)               state_d = DRAIN;
      end
      DRAIN: begin
        if (frame_end || limit_hit)     state_d = IDLE;
        else if (enable)                state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // ----------------------------------------------------------- counters
  always_comb begin
    h_d   = '0;
    v_d   = '0;
    pat_d = first_px ? pattern_sel : pat_q;
    if (active) begin
      if (h_last) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
        v_d = v_q;
      end
    end
  end

  // ------------------------------------------------ registered outputs
  always_comb begin
    de_d   = active && (h_q < H_ACT) && (v_q < V_ACT);
    hs_d   = active && (h_q >= H_HS_START) && (h_q < H_HS_END);
    vs_d   = active && (v_q >= V_VS_START) && (v_q < V_VS_END);
    done_d = frame_end;
    fcnt_d = frame_end ? fcnt_q + 16'd1 : fcnt_q;

    bar_raw = h_q / BAR_W_C;
    bar     = (bar_raw > BAR_MAX) ? 3'd7 : bar_raw[2:0];

    data_d = '0;
    comp   = '0;
    for (int k = 0; k < NUM_D; k++) begin
      case (pat_eff)
        2'd0:    comp = DSIZE'(h_q);
        2'd1:    comp = DSIZE'(v_q);
        2'd2:    comp = {DSIZE{bar[k % 3]}};
        default: comp = DSIZE'(fcnt_q);
      endcase
      data_d[(NUM_D-1-k)*DSIZE +: DSIZE] = comp;
    end
    if (!de_d) data_d = '0;
  end

  always_ff @(posedge opclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= '0;
      limit_q <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pat_q   <= pat_d;
      limit_q <= limit_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      de_q    <= de_d;
      data_q  <= data_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign out_vsync   = vs_q;
  assign out_hsync   = hs_q;
  assign out_de      = de_q;
  assign out_data    = data_q;
  assign frame_done  = done_q;
  assign frame_cnt   = fcnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_gen
//
// Small raster: H 8/2/2/2 (14 px/line), V 4/1/1/1 (7 lines), 98 px/frame.
// Expected pixel data is pushed to exp_q when a run is started; the monitor
// pops one entry every cycle out_de is high. Timing properties (hsync
// offset/width, vsync length, de bursts, frame_done spacing) are checked
// against hand-derived constants by the stimulus process.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_pattern_gen;

  localparam int W     = 24;
  localparam int FRAME = 98;

  // ------------------------------------------------ clock / reset / DUT
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          out_vsync, out_hsync, out_de, frame_done;
  logic [W-1:0]  out_data;
  logic [15:0]   frame_cnt;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .DSIZE(8), .NUM_D(3),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FRAME_MAX(3)
  ) dut (
    .opclk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .out_vsync(out_vsync), .out_hsync(out_hsync), .out_de(out_de),
    .out_data(out_data), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .dbg_state_o(dbg_state)
  );

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1;

  // ------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] bar_tbl [8] = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'hFFFF00,
                                24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'hFFFFFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_de) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_de: got pixel 0x%0h, expected no pixel at %0t", out_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pixel_data", 32'(out_data), 32'(mon_exp));
      end
    end else if (rst_n) begin
      check("data_blank", 32'(out_data), 32'd0);
    end
  end

  // --------------------------------------------------- driver tasks
  task automatic push_ramp_px(input int n);
    logic [7:0] b;
    for (int p = 0; p < n; p++) begin
      b = 8'(p);
      exp_q.push_back({b, b, b});
    end
  endtask

  task automatic push_ramp_frame();
    for (int l = 0; l < 4; l++) push_ramp_px(8);
  endtask

  task automatic push_bar_frame();
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 8; p++) exp_q.push_back(bar_tbl[p]);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_de"},    32'(out_de),     32'd0);
    check({tag, "_hsync"}, 32'(out_hsync),  32'd0);
    check({tag, "_vsync"}, 32'(out_vsync),  32'd0);
    check({tag, "_data"},  32'(out_data),   32'd0);
    check({tag, "_done"},  32'(frame_done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state),  32'(S_IDLE));
  endtask

  // ------------------------------------------------------- stimulus
  int de_rise, hs_start, bursts, vs_cnt, done_cnt, fc;
  logic prev_de, prev_hs;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);

    // Release with enable low: must stay idle
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_hold_state", 32'(dbg_state), 32'(S_IDLE));
    check("idle_hold_de", 32'(out_de), 32'd0);

    // Three frames: ramp, ramp (pattern switched mid-frame), bars (drained)
    push_ramp_frame();
    push_ramp_frame();
    push_bar_frame();
    enable = 1'b1;
    @(negedge clk);
    check("start_state_run", 32'(dbg_state), 32'(S_RUN));
    check("start_de_latency", 32'(out_de), 32'd0);

    de_rise = 0; hs_start = 0; bursts = 0; vs_cnt = 0; done_cnt = 0;
    prev_de = 1'b0; prev_hs = 1'b0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      fc = c % FRAME;
      if (c == 0) check("first_de", 32'(out_de), 32'd1);
      if (out_de && !prev_de) begin
        de_rise = c;
        bursts++;
      end
      if (out_hsync && !prev_hs) begin
        hs_start = c;
        if (fc < 56) check("hsync_offset", 32'(c - de_rise), 32'd10);
      end
      if (!out_hsync && prev_hs) check("hsync_width", 32'(c - hs_start), 32'd2);
      if (out_vsync) vs_cnt++;
      if (frame_done) begin
        done_cnt++;
        check("frame_done_pos", 32'(fc), 32'd97);
      end
      if (fc == 97) begin
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("frame_cnt", 32'(frame_cnt), 32'(c / FRAME + 1));
        check("de_bursts", 32'(bursts), 32'd4);
        check("vsync_len", 32'(vs_cnt), 32'd14);
        bursts = 0;
        vs_cnt = 0;
      end
      prev_de = out_de;
      prev_hs = out_hsync;
      if (c == FRAME + 28)         pattern_sel = 2'd2;  // frame 2, line 2
      if (c == 2 * FRAME + 14 + 3) enable = 1'b0;       // frame 3, line 1
    end
    check("frame_done_count", 32'(done_cnt), 32'd3);

    // After the drained frame: idle, quiet, count held
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_quiet("drained");
      check("drained_frame_cnt", 32'(frame_cnt), 32'd3);
    end
    check("queue_empty_a", 32'(exp_q.size()), 32'd0);

    // Reset mid-line
    pattern_sel = 2'd0;
    push_ramp_px(4);
    enable = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);          // pixels 0..3 of line 0 observed
    #2 rst_n = 1'b0;
    #1;
    check_quiet("async_reset");
    check("async_reset_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("release_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("queue_empty_b", 32'(exp_q.size()), 32'd0);

    // Restart must begin at pixel (0,0); data ramp checked by scoreboard
    push_ramp_frame();
    @(negedge clk);
    check("restart_state_run", 32'(dbg_state), 32'(S_RUN));
    check("restart_de_latency", 32'(out_de), 32'd0);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (c == 0) check("restart_first_de", 32'(out_de), 32'd1);
      if (c == 50) enable = 1'b0;
      if (c == 97) begin
        check("restart_frame_done", 32'(frame_done), 32'd1);
        check("restart_frame_cnt", 32'(frame_cnt), 32'd1);
      end
    end
    @(negedge clk);
    check_quiet("restart_end");
    check("queue_empty_c", 32'(exp_q.size()), 32'd0);

`ifdef VIDEO_GEN_FRAME_LIMIT_EN
    // Frame limit: exactly FRAME_MAX frames, then idle with enable held
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_ramp_frame();
    push_ramp_frame();
    push_ramp_frame();
    enable = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 6 * FRAME; c++) begin
      @(negedge clk);
      if (frame_done) done_cnt++;
    end
    check("limit_done_count", 32'(done_cnt), 32'd3);
    check("limit_frame_cnt", 32'(frame_cnt), 32'd3);
    check_quiet("limit_idle");
    check("queue_empty_d", 32'(exp_q.size()), 32'd0);
    enable = 1'b0;
`endif

    // ------------------------------------------------------ report
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
